// File: rtl/hospital_rover_pkg.sv
// Shared types and named rooms for the ward rover navigation controller.
// No logic; nothing here adds latency.
// No flow control; these are types and constants only.
package hospital_rover_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAVEL = 2'd1,
        DWELL  = 2'd2,
        RETURN = 2'd3
    } nav_state_t;

    // Named rooms along the corridor, in corridor order.
    localparam int unsigned HNR  = 0;  // head nurse room (home base)
    localparam int unsigned IR   = 1;
    localparam int unsigned CPR  = 2;
    localparam int unsigned ABIR = 3;
    localparam int unsigned NPR  = 4;
    localparam int unsigned ICU  = 5;
    localparam int unsigned CCU  = 6;
    localparam int unsigned BU   = 7;

endpackage

// File: rtl/rover_step_timer.sv
// Clear/enable up-counter that pulses o_tc on the last count of a run-time limit.
// o_tc is combinational from the count; it fires on the i_limit-th enabled clock after a clear.
// No backpressure; i_clr wins over counting, and the count wraps to zero on terminal count.
// Ports: clk, reset (async, active-high); i_clr, i_en, i_limit (count length); o_tc (terminal pulse).
module rover_step_timer #(
    parameter int MAX_CNT = 16,
    parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds (completed counts - 1), so the terminal count is limit-1.
    assign o_tc = i_en && (r_cnt == i_limit - CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hospital_rover_nav.sv
// Ward rover controller: takes room requests, hops one room per TRAVEL_CYCLES, dwells, returns home.
// Request outcome registered one clock after acceptance; hop k lands k*TRAVEL_CYCLES after acceptance.
// req_ready high only in IDLE/DWELL with estop low; estop overrides everything and heads home.
// Ports: clk, reset (async, active-high); req_valid/req_room/req_ready request handshake; estop;
//        current_loc, busy status; arrived, home, req_err one-cycle event pulses.
module hospital_rover_nav
    import hospital_rover_pkg::*;
#(
    parameter int NUM_ROOMS     = 8,
    parameter int LOC_W         = $clog2(NUM_ROOMS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 16,
    parameter int HOME_LOC      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LOC_W-1:0] req_room,
    output logic             req_ready,
    input  logic             estop,
    output logic [LOC_W-1:0] current_loc,
    output logic             busy,
    output logic             arrived,
    output logic             home,
    output logic             req_err
);

    // One timer serves both hop and dwell timing, so it is sized for the longer of the two.
    localparam int TMR_MAX = (TRAVEL_CYCLES > DWELL_CYCLES) ? TRAVEL_CYCLES : DWELL_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [LOC_W-1:0] HOME_ROOM = LOC_W'(HOME_LOC);

    nav_state_t       r_state, w_state_nxt;
    logic [LOC_W-1:0] r_loc, w_loc_nxt;
    logic [LOC_W-1:0] r_tgt, w_tgt_nxt;
    logic [LOC_W-1:0] w_step;
    logic             r_arrived, w_arrived_nxt;
    logic             r_home, w_home_nxt;
    logic             r_req_err, w_req_err_nxt;
    logic             w_accept, w_room_bad;
    logic             w_tmr_clr, w_tmr_en, w_tmr_tc;
    logic [TMR_W-1:0] w_tmr_limit;

    assign req_ready   = ((r_state == IDLE) || (r_state == DWELL)) && !estop;
    assign w_accept    = req_valid && req_ready;
    // Compared at 32 bits so a req_room wider than the room range is still caught.
    assign w_room_bad  = (32'(req_room) >= 32'(NUM_ROOMS));
    assign w_step      = (r_tgt > r_loc) ? (r_loc + LOC_W'(1)) : (r_loc - LOC_W'(1));
    assign w_tmr_limit = (r_state == DWELL) ? TMR_W'(DWELL_CYCLES) : TMR_W'(TRAVEL_CYCLES);

    rover_step_timer #(
        .MAX_CNT (TMR_MAX),
        .CNT_W   (TMR_W)
    ) u_step_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_tmr_limit),
        .o_tc    (w_tmr_tc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_loc_nxt     = r_loc;
        w_tgt_nxt     = r_tgt;
        w_arrived_nxt = 1'b0;
        w_home_nxt    = 1'b0;
        w_req_err_nxt = 1'b0;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;

        if (estop) begin
            // Any hop due this cycle is dropped; travel home restarts from a fresh hop period.
            w_tgt_nxt   = HOME_ROOM;
            w_tmr_clr   = 1'b1;
            w_state_nxt = (r_loc == HOME_ROOM) ? IDLE : RETURN;
        end else if (w_accept && !w_room_bad) begin
            w_tmr_clr = 1'b1;
            if (req_room == r_loc) begin
                w_state_nxt   = DWELL;
                w_arrived_nxt = 1'b1;
            end else begin
                w_tgt_nxt   = req_room;
                w_state_nxt = TRAVEL;
            end
        end else begin
            // A bad request is flagged but otherwise ignored, so a running dwell keeps its time.
            w_req_err_nxt = w_accept;
            case (r_state)
                TRAVEL, RETURN: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_tc) begin
                        w_loc_nxt = w_step;
                        if (w_step == r_tgt) begin
                            w_tmr_clr = 1'b1;
                            if (r_state == TRAVEL) begin
                                w_state_nxt   = DWELL;
                                w_arrived_nxt = 1'b1;
                            end else begin
                                w_state_nxt = IDLE;
                                w_home_nxt  = 1'b1;
                            end
                        end
                    end
                end
                DWELL: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_tc) begin
                        w_tmr_clr   = 1'b1;
                        w_tgt_nxt   = HOME_ROOM;
                        w_state_nxt = (r_loc == HOME_ROOM) ? IDLE : RETURN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_loc     <= HOME_ROOM;
            r_tgt     <= HOME_ROOM;
            r_arrived <= 1'b0;
            r_home    <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_loc     <= w_loc_nxt;
            r_tgt     <= w_tgt_nxt;
            r_arrived <= w_arrived_nxt;
            r_home    <= w_home_nxt;
            r_req_err <= w_req_err_nxt;
        end
    end

    assign current_loc = r_loc;
    assign busy        = (r_state != IDLE);
    assign arrived     = r_arrived;
    assign home        = r_home;
    assign req_err     = r_req_err;

endmodule
